// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction memory geometry and program loader state encoding.
package cpu_pkg;

    localparam int unsigned INSTR_W     = 16;
    localparam int unsigned IMEM_DEPTH  = 1024;
    localparam int unsigned IMEM_ADDR_W = 10;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StCheck,
        StDone,
        StErr
    } loader_state_e;

endpackage

// File: rtl/prog_loader_cksum.sv
// 8-bit running XOR of frame bytes; clear wins over enable.
module prog_loader_cksum
    import cpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] data,
    output logic [7:0] value
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear) begin
            sum_d = 8'h00;
        end else if (enable) begin
            sum_d = sum_q ^ data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign value = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream loader: parses a length-prefixed, XOR-checked frame into instruction memory
// and holds the CPU until a verified program is resident.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DEPTH  = IMEM_DEPTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         in_byte,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output logic [ADDR_W:0]    words_loaded
);

    loader_state_e      state_q, state_d;
    logic [15:0]        len_q, len_d;
    logic [7:0]         hi_q, hi_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [ADDR_W:0]    wl_q, wl_d;

    logic        transfer;
    logic        ck_clear;
    logic        ck_en;
    logic [7:0]  ck_value;
    logic [15:0] len_new;
    logic        len_bad;
    logic        last_word;

    assign in_ready = state_q inside {StLenHi, StLenLo, StDataHi, StDataLo, StCheck};
    assign transfer = in_valid && in_ready;

    assign len_new   = {len_q[15:8], in_byte};
    assign len_bad   = (len_new == 16'h0000) || (32'(len_new) > DEPTH);
    // words_loaded still holds the pre-write count when the LO byte is accepted
    assign last_word = (32'(wl_q) + 32'd1) == 32'(len_q);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        hi_d     = hi_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        wl_d     = wl_q;
        ck_clear = 1'b0;
        ck_en    = 1'b0;

        // Address and count advance at the end of the strobe cycle; N==DEPTH wraps to 0.
        if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
            wl_d   = wl_q + (ADDR_W + 1)'(1);
        end

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d  = StLenHi;
                    ck_clear = 1'b1;
                    wl_d     = '0;
                    addr_d   = '0;
                end
            end
            StLenHi: begin
                if (transfer) begin
                    len_d[15:8] = in_byte;
                    ck_en       = 1'b1;
                    state_d     = StLenLo;
                end
            end
            StLenLo: begin
                if (transfer) begin
                    len_d[7:0] = in_byte;
                    ck_en      = 1'b1;
                    state_d    = len_bad ? StErr : StDataHi;
                end
            end
            StDataHi: begin
                if (transfer) begin
                    hi_d    = in_byte;
                    ck_en   = 1'b1;
                    state_d = StDataLo;
                end
            end
            StDataLo: begin
                if (transfer) begin
                    wdata_d = {hi_q, in_byte};
                    we_d    = 1'b1;
                    ck_en   = 1'b1;
                    state_d = last_word ? StCheck : StDataHi;
                end
            end
            StCheck: begin
                if (transfer) begin
                    state_d = (in_byte == ck_value) ? StDone : StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            wl_q    <= wl_d;
        end
    end

    prog_loader_cksum u_cksum (
        .clock  (clock),
        .reset  (reset),
        .clear  (ck_clear),
        .enable (ck_en),
        .data   (in_byte),
        .value  (ck_value)
    );

    // A strobe coinciding with reset must not reach memory
    assign mem_we       = we_q && !reset;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign words_loaded = wl_q;
    assign done         = (state_q == StDone);
    assign error        = (state_q == StErr);
    assign cpu_hold     = (state_q != StDone);

endmodule
